// File: rtl/arb_mux.sv
// arb_mux -- N-channel arbiter feeding a one-entry registered output slot.
//
// Each cycle a one-hot grant is picked among the requesting channels. The
// granted channel sees in_ready when the output slot can take a word (empty,
// or being drained this cycle). An accepted word appears on out_data/out_ch
// exactly one cycle later. Drain and load can happen in the same cycle, so
// the block sustains one word per cycle.
//
// Configuration macro: ARB_MUX_RR_EN
//   defined   -> round-robin arbitration (search starts at a rotating pointer)
//   undefined -> fixed priority, lowest channel index wins (no pointer state)
//
// Parameters
//   XLEN      data width per channel
//   CH        number of input channels (2..16)
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_data   CH*XLEN   channel i at [i*XLEN +: XLEN]
//   in_valid  CH        per-channel request
//   in_ready  CH        per-channel accept (combinational, at most one high)
//   out_data  XLEN      registered selected word
//   out_valid 1         out_data holds an unconsumed word
//   out_ready 1         downstream accept
//   out_ch    clog2(CH) channel that supplied out_data

// Per-channel slice: gates the accept and contributes its data to the
// AND-OR output mux when granted.
module arb_mux_lane #(
  parameter int XLEN = 32
) (
  input  logic            rst,
  input  logic            grant,
  input  logic            slot_free,
  input  logic [XLEN-1:0] data,
  output logic            ready,
  output logic [XLEN-1:0] dsel
);
  assign ready = !rst && grant && slot_free;
  assign dsel  = grant ? data : '0;
endmodule

module arb_mux #(
  parameter int XLEN = 32,
  parameter int CH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*XLEN-1:0]    in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(CH)-1:0] out_ch
);
  localparam int CW = $clog2(CH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic                        slot_free;
  logic                        xfer;
  logic [CH-1:0]               grant;
  logic [CW-1:0]               gidx;
  logic [XLEN-1:0]             gdata;
  logic [CH-1:0][XLEN-1:0]     lane_dsel;

  assign out_valid = (state == FULL);
  assign slot_free = !out_valid || out_ready;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARB_MUX_RR_EN
  logic [CW-1:0] ptr;

  // Rotating search: channel ptr has top priority, then ptr+1, wrapping.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CH) idx = idx - CH;
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only when a word is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (xfer)
      ptr <= (gidx == CW'(CH-1)) ? '0 : gidx + CW'(1);
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (!found && in_valid[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-channel lanes: accept gating and data select
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < CH; i++) begin : g_lane
    arb_mux_lane #(.XLEN(XLEN)) u_lane (
      .rst       (rst),
      .grant     (grant[i]),
      .slot_free (slot_free),
      .data      (in_data[i*XLEN +: XLEN]),
      .ready     (in_ready[i]),
      .dsel      (lane_dsel[i])
    );
  end

  // Grant is one-hot, so OR-reducing the gated lane data and the lane indices
  // yields the winner's word and index without a priority encoder.
  always_comb begin
    gdata = '0;
    gidx  = '0;
    for (int k = 0; k < CH; k++) begin
      gdata = gdata | lane_dsel[k];
      if (grant[k]) gidx = gidx | CW'(k);
    end
  end

  assign xfer = |(in_valid & in_ready);

  // ---------------------------------------------------------------------------
  // Output slot FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (out_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Payload only changes on a load; a plain drain leaves the last word visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (xfer) begin
      out_data <= gdata;
      out_ch   <= gidx;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
  localparam int XLEN = 32;
  localparam int CH   = 4;

  logic                clk;
  logic                rst;
  logic [CH*XLEN-1:0]  in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic [XLEN-1:0]     out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_ch;

  int total = 0;
  int bad   = 0;

  arb_mux #(.XLEN(XLEN), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  erdy;
    logic        eov;
    logic [31:0] eod;
    logic [1:0]  ech;
  } vec_t;

  vec_t tv[9];

  function automatic logic [31:0] dat(input int ch, input int v);
    return 32'h1000_0000 * (ch + 1) + v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int ch, input logic [31:0] val);
    in_data[ch*XLEN +: XLEN] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // {in_valid, out_ready, in_ready, out_valid', out_data', out_ch'}
    tv[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,     2'd0};
    tv[1] = '{4'b0100, 1'b1, 4'b0100, 1'b1, dat(2, 1), 2'd2};
    tv[2] = '{4'b1010, 1'b0, 4'b0000, 1'b1, dat(2, 1), 2'd2};
`ifdef ARB_MUX_RR_EN
    tv[3] = '{4'b1010, 1'b1, 4'b1000, 1'b1, dat(3, 3), 2'd3};
`else
    tv[3] = '{4'b1010, 1'b1, 4'b0010, 1'b1, dat(1, 3), 2'd1};
`endif
    tv[4] = '{4'b1000, 1'b1, 4'b1000, 1'b1, dat(3, 4), 2'd3};
    tv[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, dat(3, 4), 2'd3};
    tv[6] = '{4'b0000, 1'b0, 4'b0000, 1'b0, dat(3, 4), 2'd3};
    tv[7] = '{4'b1001, 1'b0, 4'b0001, 1'b1, dat(0, 7), 2'd0};
    tv[8] = '{4'b1000, 1'b0, 4'b0000, 1'b1, dat(0, 7), 2'd0};

    in_data = '0;
    in_valid = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", out_data, 32'h0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    do_reset();

    // Table-driven sequence
    for (int v = 0; v < 9; v++) begin
      for (int c = 0; c < CH; c++) setd(c, dat(c, v));
      in_valid  = tv[v].iv;
      out_ready = tv[v].ordy;
      #1;
      chk($sformatf("v%0d_rdy", v), 32'(in_ready), 32'(tv[v].erdy));
      step();
      chk($sformatf("v%0d_ov", v), 32'(out_valid), 32'(tv[v].eov));
      chk($sformatf("v%0d_od", v), out_data, tv[v].eod);
      chk($sformatf("v%0d_ch", v), 32'(out_ch), 32'(tv[v].ech));
      #1;
    end

    // Single transfer with a known word
    step();
    do_reset();
    for (int c = 0; c < CH; c++) setd(c, 32'hA0 + c);
    setd(2, 32'hDEAD_BEEF);
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("single_rdy", 32'(in_ready), 32'h4);
    step();
    chk("single_ov", 32'(out_valid), 32'd1);
    chk("single_od", out_data, 32'hDEAD_BEEF);
    chk("single_ch", 32'(out_ch), 32'd2);

    // Backpressure: slot full and stalled for 3 cycles
    in_valid = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 32'(in_ready), 32'd0);
      step();
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_od", out_data, 32'hDEAD_BEEF);
      chk("bp_ch", 32'(out_ch), 32'd2);
    end
    out_ready = 1'b1;
    #1;
`ifdef ARB_MUX_RR_EN
    chk("bp_rel_rdy", 32'(in_ready), 32'h8);
    step();
    chk("bp_rel_od", out_data, 32'hA3);
    chk("bp_rel_ch", 32'(out_ch), 32'd3);
`else
    chk("bp_rel_rdy", 32'(in_ready), 32'h1);
    step();
    chk("bp_rel_od", out_data, 32'hA0);
    chk("bp_rel_ch", 32'(out_ch), 32'd0);
`endif
    chk("bp_rel_ov", 32'(out_valid), 32'd1);

    // Arbitration policy over several back-to-back transfers
    step();
    do_reset();
    out_ready = 1'b1;
`ifdef ARB_MUX_RR_EN
    begin
      logic [1:0] seq [6];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      in_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
        step();
        chk("rr_ov", 32'(out_valid), 32'd1);
        chk($sformatf("rr_ch%0d", k), 32'(out_ch), 32'(seq[k]));
      end
    end
`else
    in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fp_rdy", 32'(in_ready), 32'h2);
      step();
      chk("fp_ov", 32'(out_valid), 32'd1);
      chk($sformatf("fp_ch%0d", k), 32'(out_ch), 32'd1);
    end
`endif

    // Throughput: channel 0 streams 1..8 with no gaps
    in_valid = 4'b0001;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      setd(0, 32'(k));
      #1;
      chk("tp_rdy", 32'(in_ready), 32'h1);
      step();
      chk($sformatf("tp_ov%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("tp_od%0d", k), out_data, 32'(k));
      chk("tp_ch", 32'(out_ch), 32'd0);
    end
    in_valid = '0;
    step();
    chk("tp_drain_ov", 32'(out_valid), 32'd0);
    chk("tp_drain_od", out_data, 32'd8);

    // Reset asserted while FULL and stalled
    setd(2, 32'h5555_AAAA);
    setd(0, 32'h0BAD_F00D);
    in_valid = 4'b0100;
    out_ready = 1'b0;
    step();
    chk("mr_full_ov", 32'(out_valid), 32'd1);
    in_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("mr_ov", 32'(out_valid), 32'd0);
    chk("mr_od", out_data, 32'h0);
    chk("mr_ch", 32'(out_ch), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd0);
    step();
    chk("mr_hold_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_resume_rdy", 32'(in_ready), 32'h1);
    step();
    chk("mr_resume_ov", 32'(out_valid), 32'd1);
    chk("mr_resume_od", out_data, 32'h0BAD_F00D);
    chk("mr_resume_ch", 32'(out_ch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width per channel.
REQ-002 SHALL have parameter CH, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  CH*XLEN  channel i occupies bits [i*XLEN +: XLEN].
REQ-006 SHALL have port in_valid  input  CH  per-channel request.
REQ-007 SHALL have port in_ready  output  CH  per-channel accept, combinational.
REQ-008 SHALL have port out_data  output  XLEN  registered selected data.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_ch  output  $clog2(CH)  registered index of the channel that supplied out_data.

Function
REQ-012 SHALL contain a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define slot_free = !out_valid || out_ready.
REQ-014 SHALL compute a one-hot grant g among asserted in_valid bits per the arbitration policy (REQ-029/030); grant is zero when no in_valid is set.
REQ-015 SHALL drive in_ready[i] = grant[i] && slot_free; at most one in_ready bit high per cycle.
REQ-016 SHALL on transfer (in_valid[g] && in_ready[g]) load out_data <= channel g data, out_ch <= g, out_valid <= 1 on the next edge; latency exactly 1 cycle.
REQ-017 SHALL, on out_valid && out_ready with no new transfer, clear out_valid on the next edge; out_data and out_ch keep their last values.
REQ-018 SHALL support simultaneous drain and load in one cycle (FULL->FULL), sustaining one word per cycle.
REQ-019 SHALL hold out_data and out_ch stable while out_valid && !out_ready; all in_ready low in that case.
REQ-020 SHALL never drop or duplicate a word: each accepted input appears exactly once on the output.
REQ-021 SHALL not depend on in_valid withdrawal rules; a channel whose in_valid drops without a transfer is simply not granted.
REQ-022 SHALL update the arbitration pointer only on a transfer, never on a stalled or idle cycle.

Reset
REQ-023 SHALL, while rst is high, force out_valid=0, out_data=0, out_ch=0, pointer=0, asynchronously.
REQ-024 SHALL force in_ready to all-zeros while rst is high.
REQ-025 SHALL discard any FULL word when rst asserts mid-operation; no transfer counted in that cycle.
REQ-026 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL use macro ARB_MUX_RR_EN to select the arbitration policy.
REQ-028 SHALL keep the port list identical with and without the macro.
REQ-029 SHALL, with ARB_MUX_RR_EN defined, arbitrate round-robin: search starts at pointer, after granting g pointer <= g+1, wrapping CH-1 -> 0.
REQ-030 SHALL, without ARB_MUX_RR_EN, arbitrate fixed priority, lowest index wins; the pointer register is not implemented.

Verification (CH=4, XLEN=32)
REQ-031 SHALL cover reset: assert rst mid-FULL with out_ready=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000 immediately, without waiting for clk.
REQ-032 SHALL cover single transfer: in_valid=4'b0100, data2=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_ch=2.
REQ-033 SHALL cover backpressure: FULL with out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0 each cycle, out_data unchanged; out_ready=1 then yields a load in the same cycle.
REQ-034 SHALL cover round-robin wrap (macro on): in_valid=4'b1111, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1.
REQ-035 SHALL cover fixed priority (macro off): in_valid=4'b1010 held, out_ready=1 -> out_ch=1 every cycle; channel 3 never granted.
REQ-036 SHALL cover throughput: channel 0 streams 0x1..0x8 with out_ready=1 -> 8 consecutive out_valid cycles, values in order, no gaps.
